// File: rtl/uart_echo_ctrl_if.sv
// uart_echo_ctrl_if
// Groups the character handshake between the echo controller and its
// UART receiver/transmitter.
//   rx_data/rx_valid : received character with a one-cycle strobe (no backpressure)
//   tx_data/tx_valid : character offered to the transmitter
//   tx_ready         : transmitter accepts tx_data when high together with tx_valid
// The master modport is the side that owns the UART, and the slave modport is the echo controller.
interface uart_echo_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// uart_echo_ctrl
// Echoes every received character back to the transmitter through a FIFO
// and a registered output stage. It also watches the traffic for an
// ESC + 0xF? command that selects a new line mode. A new mode takes
// effect only after every queued echo has left, so characters that are
// already queued go out in the old mode.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : rx_data/rx_valid in, tx_data/tx_valid out, tx_ready in
//   mode         : active line mode
//   armed        : ESC seen, waiting for the command character
//   mode_pending : a decoded mode is waiting to be applied
//   fifo_level   : occupied FIFO entries (does not count the output stage)
//   overflow     : sticky flag, a received character was dropped
//   ovf_clr      : clears overflow (a drop on the same edge wins)
module uart_echo_ctrl #(
  parameter int                 DATA_W   = 8,
  parameter int                 DEPTH    = 16,
  parameter int                 MODE_W   = 4,
  parameter logic [MODE_W-1:0]  MODE_RST = MODE_W'(1),
  parameter logic [DATA_W-1:0]  ESC      = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_echo_ctrl_if.slave            bus,
  output logic [MODE_W-1:0]          mode,
  output logic                       armed,
  output logic                       mode_pending,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, ARMED} state_t;

  // FIFO storage has no reset, so it can map onto RAM.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;

  logic              tx_valid_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic              overflow_reg;

  state_t            state_reg;
  state_t            state_next;
  logic              cmd_hit;
  logic [MODE_W-1:0] pending_reg;
  logic              mode_pending_reg;
  logic [MODE_W-1:0] mode_reg;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic apply;

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == FULL_LVL);

  // The head moves into the stage whenever the stage is empty or is being
  // drained on this edge. This gives back-to-back output with no bubble.
  assign pop  = !fifo_empty && (!tx_valid_reg || bus.tx_ready);
  // A pop on the same edge frees a slot, so a push into a full FIFO still succeeds.
  assign push = bus.rx_valid && (!fifo_full || pop);
  assign drop = bus.rx_valid && !push;

  // A new mode is applied only after all echoes have left the block.
  assign apply = mode_pending_reg && fifo_empty && !tx_valid_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Output stage. tx_data keeps its value until the next load, so it stays
  // stable while the transmitter stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else if (pop) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= mem[rd_ptr_reg];
    end else if (tx_valid_reg && bus.tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  // Command decoder. It sees every received character, including the ones
  // that the FIFO drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_hit    = 1'b0;
    if (bus.rx_valid) begin
      case (state_reg)
        IDLE: begin
          if (bus.rx_data == ESC) begin
            state_next = ARMED;
          end
        end
        ARMED: begin
          // ESC is checked first. With the default ESC the top nibble is
          // also all ones, and a repeated ESC must keep the decoder armed.
          if (bus.rx_data == ESC) begin
            state_next = ARMED;
          end else if (bus.rx_data[DATA_W-1 -: 4] == 4'hF) begin
            cmd_hit    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg      <= '0;
      mode_pending_reg <= 1'b0;
      mode_reg         <= MODE_RST;
    end else begin
      if (apply) begin
        mode_reg <= pending_reg;
      end
      // A fresh command overwrites any value that has not been applied yet.
      if (cmd_hit) begin
        pending_reg      <= bus.rx_data[MODE_W-1:0];
        mode_pending_reg <= 1'b1;
      end else if (apply) begin
        mode_pending_reg <= 1'b0;
      end
    end
  end

  assign bus.tx_valid = tx_valid_reg;
  assign bus.tx_data  = tx_data_reg;
  assign mode         = mode_reg;
  assign armed        = (state_reg == ARMED);
  assign mode_pending = mode_pending_reg;
  assign fifo_level   = level_reg;
  assign overflow     = overflow_reg;

endmodule
